cblk_hdr_field_gen: RTL
=======================

Name: cblk_hdr_field_gen

Overview:
Upstream neighbour of bit_assembler in the packet-header path of j2K_encoder. For each included code-block it takes the number of coding passes and the codeword segment length. It encodes the JPEG2000 number-of-passes codeword, the Lblock comma code and the length field. These are issued as a sequence of field commands on the valid_o/hdr_ready_i interface that bit_assembler consumes.

Parameters:
BIT_CNT_W, 6, width of bit_cnt_o; must match bit_assembler
HDR_DATA_W, 32, width of hdr_data_o; must match bit_assembler
NP_W, 8, width of number-of-passes input
LEN_W, 16, width of segment length input
LBLOCK_INIT, 3, initial Lblock value per code-block

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
s_cblk_valid_i  in  1  code-block descriptor valid
s_cblk_ready_o  out  1  descriptor accepted when valid and ready are both high
s_cblk_np_i  in  NP_W  number of coding passes; legal range 1..164
s_cblk_len_i  in  LEN_W  segment length in bytes
s_cblk_last_i  in  1  last code-block of the packet
valid_o  out  1  field command valid
hdr_last_o  out  1  final field of the packet
insert_zero_o  out  1  field is bit_cnt_o zero bits
insert_ones_o  out  1  field is bit_cnt_o one bits
bit_cnt_o  out  BIT_CNT_W  field length in bits
hdr_data_o  out  HDR_DATA_W  raw field, LSB-aligned, transmitted MSB-first
hdr_ready_i  in  1  bit_assembler accepts field
err_o  out  1  one-cycle pulse on an illegal np

Behaviour:
- Interface decision: one clock, clk; reset rst_n is synchronous and active-low.
- Reset state:
  - all outputs 0, except s_cblk_ready_o=1.
  - FSM goes to IDLE.
- Output handshake:
  - A field transfers on a rising edge with valid_o & hdr_ready_i.
  - While valid_o=1 and hdr_ready_i=0, all field outputs are held stable.
  - valid_o is never withdrawn before the transfer.
- At most one of insert_zero_o / insert_ones_o is high.
- For raw fields both flags are 0 and hdr_data_o bits above bit_cnt_o are 0.
- FSM states: IDLE, CALC, PASSES, ONES, ZERO, LEN.
- IDLE:
  - s_cblk_ready_o=1.
  - On accept, register np, len and last, then go to CALC. s_cblk_ready_o=0 until the FSM returns to IDLE.
- CALC (1 cycle), all arithmetic unsigned:
  - flog2 = floor(log2(np)).
  - bitlen = index of the MSB of len, plus 1 (0 when len=0).
  - k = max(0, bitlen - LBLOCK_INIT - flog2).
  - nbits = LBLOCK_INIT + k + flog2.
  - If np=0 or np>164: pulse err_o, issue no fields, return to IDLE (hdr_last is not generated).
  - Otherwise go to PASSES.
- PASSES: issue one raw field according to np:
  - np=1: cnt 1, data 0.
  - np=2: cnt 2, data 0b10.
  - np 3..5: cnt 4, data 0b1100|(np-3).
  - np 6..36: cnt 9, data 0x1E0|(np-6).
  - np 37..164: cnt 16, data 0xFF80|(np-37).
- Transitions after PASSES:
  - PASSES → ONES if k>0, else → ZERO.
- ONES:
  - insert_ones_o=1, bit_cnt_o=k.
  - Then → ZERO.
- ZERO:
  - insert_zero_o=1, bit_cnt_o=1 (comma terminator).
  - Then → LEN.
- LEN:
  - Raw field, cnt=nbits, data=len.
  - hdr_last_o = registered last.
  - On transfer → IDLE.
- Throughput: a new descriptor is accepted in the cycle after the LEN transfer completes. There is no overlap between code-blocks.
- Lblock is restarted at LBLOCK_INIT for every code-block (single quality layer). The block keeps no state across code-blocks.
- Reset mid-operation aborts the current code-block immediately; no partial field is re-issued.
- Bounds: nbits ≤ 16 and k ≤ 13, so every field fits BIT_CNT_W/HDR_DATA_W.

Optional Feature:
CBLK_INCL_BIT_EN
- Defined:
  - An INCL state is inserted between CALC and PASSES. It issues a raw 1-bit field with data 1 (code-block inclusion bit).
  - An illegal np=0 descriptor instead issues a single raw 1-bit 0, carrying hdr_last_o=last, and still pulses err_o.
- Undefined: INCL is absent. Inclusion is signalled by the tag-tree stage.

Decomposition:
- Shared package j2k_hdr_pkg holds:
  - FSM state encoding constants.
  - Passes codeword prefixes (0x2, 0xC, 0x1E0, 0xFF80) and range bounds (2, 5, 36, 164).
  - LBLOCK_INIT.
- One sub-module, hdr_msb_index: a combinational priority encoder returning the MSB index plus 1. It is instantiated twice, for np and len.

Test Plan:
- np=1, len=5 → PASSES {cnt1, data0}; ZERO {cnt1}; LEN {cnt3, data5}. No ONES field.
- np=4, len=100, last=1 → PASSES {cnt4, 0xD}; ONES {cnt2}; ZERO {cnt1}; LEN {cnt7, 100, hdr_last_o=1}.
- np=37, len=40000 → PASSES {cnt16, 0xFF80}; ONES {cnt8}; ZERO; LEN {cnt16, 0x9C40}.
- np=6, len=10 with hdr_ready_i low for 3 cycles on each field → outputs held stable; no duplicate or dropped fields; s_cblk_ready_o stays 0 until LEN transfers.
- np=165, then np=0 → err_o high for exactly 1 cycle each; valid_o never asserts; s_cblk_ready_o returns to 1 within 2 cycles.
- rst_n low during ONES of np=200-free case np=20, len=1000 → all outputs 0 on the next edge and s_cblk_ready_o=1. The next descriptor, np=2, len=3, gives PASSES {cnt2, 0b10}; ZERO; LEN {cnt4, 3}.

Source files
------------

// File: rtl/j2k_hdr_pkg.sv
// Shared constants for the JPEG2000 packet-header field path: FSM encoding,
// number-of-passes codeword prefixes/range bounds and the default Lblock.
package j2k_hdr_pkg;

    localparam int LBLOCK_INIT_DEF = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CALC   = 3'd1,
        ST_INCL   = 3'd2,
        ST_PASSES = 3'd3,
        ST_ONES   = 3'd4,
        ST_ZERO   = 3'd5,
        ST_LEN    = 3'd6
    } hdr_state_e;

    localparam logic [15:0] PFX_NP2  = 16'h0002;
    localparam logic [15:0] PFX_NP3  = 16'h000C;
    localparam logic [15:0] PFX_NP6  = 16'h01E0;
    localparam logic [15:0] PFX_NP37 = 16'hFF80;

    localparam logic [7:0] NP_B2  = 8'd2;
    localparam logic [7:0] NP_B5  = 8'd5;
    localparam logic [7:0] NP_B36 = 8'd36;
    localparam logic [7:0] NP_MAX = 8'd164;

    typedef struct packed {
        logic [4:0]  cnt;
        logic [15:0] data;
    } pass_cw_t;

    // Number-of-passes codeword; only meaningful for np in 1..NP_MAX.
    function automatic pass_cw_t passes_code(input logic [7:0] np);
        pass_cw_t cw;
        cw.cnt  = 5'd1;
        cw.data = 16'h0000;
        if (np <= 8'd1) begin
            cw.cnt  = 5'd1;
            cw.data = 16'h0000;
        end else if (np == NP_B2) begin
            cw.cnt  = 5'd2;
            cw.data = PFX_NP2;
        end else if (np <= NP_B5) begin
            cw.cnt  = 5'd4;
            cw.data = PFX_NP3 | 16'(np - 8'd3);
        end else if (np <= NP_B36) begin
            cw.cnt  = 5'd9;
            cw.data = PFX_NP6 | 16'(np - 8'd6);
        end else begin
            cw.cnt  = 5'd16;
            cw.data = PFX_NP37 | 16'(np - 8'd37);
        end
        return cw;
    endfunction

endpackage

// File: rtl/cblk_hdr_field_gen_if.sv
// Descriptor input and field-command output bus of cblk_hdr_field_gen.
// slave = the generator, master = the descriptor source / bit_assembler side.
interface cblk_hdr_field_gen_if #(
    parameter int BIT_CNT_W  = 6,
    parameter int HDR_DATA_W = 32,
    parameter int NP_W       = 8,
    parameter int LEN_W      = 16
) ();
    logic                  s_cblk_valid_i;
    logic                  s_cblk_ready_o;
    logic [NP_W-1:0]       s_cblk_np_i;
    logic [LEN_W-1:0]      s_cblk_len_i;
    logic                  s_cblk_last_i;
    logic                  valid_o;
    logic                  hdr_last_o;
    logic                  insert_zero_o;
    logic                  insert_ones_o;
    logic [BIT_CNT_W-1:0]  bit_cnt_o;
    logic [HDR_DATA_W-1:0] hdr_data_o;
    logic                  hdr_ready_i;
    logic                  err_o;

    modport master (
        output s_cblk_valid_i, s_cblk_np_i, s_cblk_len_i, s_cblk_last_i, hdr_ready_i,
        input  s_cblk_ready_o, valid_o, hdr_last_o, insert_zero_o, insert_ones_o,
               bit_cnt_o, hdr_data_o, err_o
    );

    modport slave (
        input  s_cblk_valid_i, s_cblk_np_i, s_cblk_len_i, s_cblk_last_i, hdr_ready_i,
        output s_cblk_ready_o, valid_o, hdr_last_o, insert_zero_o, insert_ones_o,
               bit_cnt_o, hdr_data_o, err_o
    );
endinterface

// File: rtl/hdr_msb_index.sv
// Combinational priority encoder: index of the most significant set bit plus 1,
// 0 for an all-zero input.
module hdr_msb_index #(
    parameter int W  = 16,
    parameter int IW = $clog2(W + 1)
) (
    input  logic [W-1:0]  val,
    output logic [IW-1:0] idx
);
    always_comb begin
        idx = '0;
        for (int i = 0; i < W; i++) begin
            if (val[i]) idx = IW'(i + 1);
        end
    end
endmodule

// File: rtl/cblk_hdr_field_gen.sv
// Per-code-block header field generator: number-of-passes codeword, Lblock comma
// code and length field. Optional macro CBLK_INCL_BIT_EN adds the inclusion bit.
module cblk_hdr_field_gen
    import j2k_hdr_pkg::*;
#(
    parameter int BIT_CNT_W   = 6,
    parameter int HDR_DATA_W  = 32,
    parameter int NP_W        = 8,
    parameter int LEN_W       = 16,
    parameter int LBLOCK_INIT = LBLOCK_INIT_DEF
) (
    input logic clk,
    input logic rst_n,
    cblk_hdr_field_gen_if.slave bus
);
    localparam int NP_IW  = $clog2(NP_W + 1);
    localparam int LEN_IW = $clog2(LEN_W + 1);

    hdr_state_e            state_q;
    logic [NP_W-1:0]       np_q;
    logic [LEN_W-1:0]      len_q;
    logic                  last_q;
    logic [7:0]            k_q;
    logic [7:0]            nbits_q;
`ifdef CBLK_INCL_BIT_EN
    logic                  incl_abort_q;
`endif

    logic                  ready_q, valid_q, hlast_q, zero_q, ones_q, err_q;
    logic [BIT_CNT_W-1:0]  cnt_q;
    logic [HDR_DATA_W-1:0] data_q;

    logic [NP_IW-1:0]      np_msb;
    logic [LEN_IW-1:0]     len_msb;
    logic [7:0]            flog2_c, base_c, bitlen_c, k_c;
    logic                  np_bad_c;
    pass_cw_t              pcw_c;
    logic [BIT_CNT_W-1:0]  pass_cnt_c;
    logic [HDR_DATA_W-1:0] pass_data_c;
    logic                  xfer;

    hdr_msb_index #(.W(NP_W))  u_np_msb  (.val(np_q),  .idx(np_msb));
    hdr_msb_index #(.W(LEN_W)) u_len_msb (.val(len_q), .idx(len_msb));

    // nbits = LBLOCK_INIT + k + flog2 reduces to max(bitlen, LBLOCK_INIT + flog2).
    always_comb begin
        flog2_c     = 8'(np_msb) - 8'd1;
        base_c      = 8'(LBLOCK_INIT) + flog2_c;
        bitlen_c    = 8'(len_msb);
        k_c         = (bitlen_c > base_c) ? (bitlen_c - base_c) : 8'd0;
        np_bad_c    = (np_q == '0) || (np_q > NP_W'(NP_MAX));
        pcw_c       = passes_code(8'(np_q));
        pass_cnt_c  = BIT_CNT_W'(pcw_c.cnt);
        pass_data_c = HDR_DATA_W'(pcw_c.data);
    end

    assign xfer = valid_q & bus.hdr_ready_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            np_q         <= '0;
            len_q        <= '0;
            last_q       <= 1'b0;
            k_q          <= '0;
            nbits_q      <= '0;
`ifdef CBLK_INCL_BIT_EN
            incl_abort_q <= 1'b0;
`endif
            ready_q      <= 1'b1;
            valid_q      <= 1'b0;
            hlast_q      <= 1'b0;
            zero_q       <= 1'b0;
            ones_q       <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            data_q       <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.s_cblk_valid_i) begin
                        np_q    <= bus.s_cblk_np_i;
                        len_q   <= bus.s_cblk_len_i;
                        last_q  <= bus.s_cblk_last_i;
                        ready_q <= 1'b0;
                        state_q <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    k_q     <= k_c;
                    nbits_q <= base_c + k_c;
                    if (np_bad_c) begin
                        err_q <= 1'b1;
`ifdef CBLK_INCL_BIT_EN
                        // np=0 still reports the block as not included.
                        if (np_q == '0) begin
                            valid_q      <= 1'b1;
                            cnt_q        <= BIT_CNT_W'(1);
                            data_q       <= '0;
                            hlast_q      <= last_q;
                            incl_abort_q <= 1'b1;
                            state_q      <= ST_INCL;
                        end else begin
                            ready_q <= 1'b1;
                            state_q <= ST_IDLE;
                        end
`else
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
`endif
                    end else begin
                        valid_q <= 1'b1;
`ifdef CBLK_INCL_BIT_EN
                        cnt_q        <= BIT_CNT_W'(1);
                        data_q       <= HDR_DATA_W'(1);
                        incl_abort_q <= 1'b0;
                        state_q      <= ST_INCL;
`else
                        cnt_q   <= pass_cnt_c;
                        data_q  <= pass_data_c;
                        state_q <= ST_PASSES;
`endif
                    end
                end
`ifdef CBLK_INCL_BIT_EN
                ST_INCL: begin
                    if (xfer) begin
                        if (incl_abort_q) begin
                            valid_q <= 1'b0;
                            hlast_q <= 1'b0;
                            cnt_q   <= '0;
                            ready_q <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q   <= pass_cnt_c;
                            data_q  <= pass_data_c;
                            state_q <= ST_PASSES;
                        end
                    end
                end
`endif
                ST_PASSES: begin
                    if (xfer) begin
                        data_q <= '0;
                        if (k_q != 8'd0) begin
                            ones_q  <= 1'b1;
                            cnt_q   <= BIT_CNT_W'(k_q);
                            state_q <= ST_ONES;
                        end else begin
                            zero_q  <= 1'b1;
                            cnt_q   <= BIT_CNT_W'(1);
                            state_q <= ST_ZERO;
                        end
                    end
                end
                ST_ONES: begin
                    if (xfer) begin
                        ones_q  <= 1'b0;
                        zero_q  <= 1'b1;
                        cnt_q   <= BIT_CNT_W'(1);
                        state_q <= ST_ZERO;
                    end
                end
                ST_ZERO: begin
                    if (xfer) begin
                        zero_q  <= 1'b0;
                        cnt_q   <= BIT_CNT_W'(nbits_q);
                        data_q  <= HDR_DATA_W'(len_q);
                        hlast_q <= last_q;
                        state_q <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (xfer) begin
                        valid_q <= 1'b0;
                        hlast_q <= 1'b0;
                        cnt_q   <= '0;
                        data_q  <= '0;
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    hlast_q <= 1'b0;
                    zero_q  <= 1'b0;
                    ones_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.s_cblk_ready_o = ready_q;
    assign bus.valid_o        = valid_q;
    assign bus.hdr_last_o     = hlast_q;
    assign bus.insert_zero_o  = zero_q;
    assign bus.insert_ones_o  = ones_q;
    assign bus.bit_cnt_o      = cnt_q;
    assign bus.hdr_data_o     = data_q;
    assign bus.err_o          = err_q;

endmodule
